// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state type for the AXI4-Lite master.
package axi_lite_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT_B,
        RD,
        WAIT_R,
        RSP
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out.
// Optional misaligned-address rejection when AXI_LITE_MASTER_ALIGN_CHECK_EN is defined.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_t              state, state_nxt;
    logic                cmd_ready_nxt;
    logic                rsp_valid_nxt, rsp_write_nxt;
    logic [DATA_W-1:0]   rsp_rdata_nxt;
    logic [1:0]          rsp_resp_nxt;
    logic [ADDR_W-1:0]   awaddr_nxt, araddr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [STRB_W-1:0]   wstrb_nxt;
    logic                awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;

    // State and every output are registered together.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cmd_ready     <= cmd_ready_nxt;
            rsp_valid     <= rsp_valid_nxt;
            rsp_write     <= rsp_write_nxt;
            rsp_rdata     <= rsp_rdata_nxt;
            rsp_resp      <= rsp_resp_nxt;
            M_AXI_AWADDR  <= awaddr_nxt;
            M_AXI_AWVALID <= awvalid_nxt;
            M_AXI_WDATA   <= wdata_nxt;
            M_AXI_WSTRB   <= wstrb_nxt;
            M_AXI_WVALID  <= wvalid_nxt;
            M_AXI_BREADY  <= bready_nxt;
            M_AXI_ARADDR  <= araddr_nxt;
            M_AXI_ARVALID <= arvalid_nxt;
            M_AXI_RREADY  <= rready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rsp_valid_nxt = rsp_valid;
        rsp_write_nxt = rsp_write;
        rsp_rdata_nxt = rsp_rdata;
        rsp_resp_nxt  = rsp_resp;
        awaddr_nxt    = M_AXI_AWADDR;
        awvalid_nxt   = M_AXI_AWVALID;
        wdata_nxt     = M_AXI_WDATA;
        wstrb_nxt     = M_AXI_WSTRB;
        wvalid_nxt    = M_AXI_WVALID;
        bready_nxt    = M_AXI_BREADY;
        araddr_nxt    = M_AXI_ARADDR;
        arvalid_nxt   = M_AXI_ARVALID;
        rready_nxt    = M_AXI_RREADY;

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rsp_write_nxt = cmd_write;
`ifdef AXI_LITE_MASTER_ALIGN_CHECK_EN
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_nxt     = RSP;
                        rsp_valid_nxt = 1'b1;
                        rsp_resp_nxt  = RESP_SLVERR;
                        rsp_rdata_nxt = '0;
                    end else
`endif
                    if (cmd_write) begin
                        state_nxt   = WR;
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                        wstrb_nxt   = cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = RD;
                        araddr_nxt  = cmd_addr;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            // AW and W retire independently; leave once neither is pending.
            WR: begin
                awvalid_nxt = M_AXI_AWVALID && !M_AXI_AWREADY;
                wvalid_nxt  = M_AXI_WVALID && !M_AXI_WREADY;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    state_nxt  = WAIT_B;
                    bready_nxt = 1'b1;
                end
            end
            WAIT_B: begin
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    state_nxt     = RSP;
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_resp_nxt  = M_AXI_BRESP;
                end
            end
            RD: begin
                if (M_AXI_ARREADY) begin
                    state_nxt   = WAIT_R;
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                end
            end
            WAIT_R: begin
                if (M_AXI_RVALID && M_AXI_RREADY) begin
                    state_nxt     = RSP;
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = M_AXI_RDATA;
                    rsp_resp_nxt  = M_AXI_RRESP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter ADDR_W, 32, address width of command and AXI address channels.
REQ-002 Parameter DATA_W, 32, data width; WSTRB width is DATA_W/8.
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESETN  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr, cmd_wdata, cmd_wstrb  input  ADDR_W, DATA_W, DATA_W/8  command payload.
REQ-008 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-009 rsp_write, rsp_rdata, rsp_resp  output  1, DATA_W, 2  completed type, read data (0 for writes), BRESP/RRESP.
REQ-010 M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  AXI4-Lite master ports, directions and widths mirror axi_lite_slave S_AXI_* ports.

Function
REQ-011 FSM states IDLE, WR, WAIT_B, RD, WAIT_R, RSP; one transaction outstanding at a time.
REQ-012 cmd_ready high only in IDLE; command accepted on cmd_valid && cmd_ready; payload registered on acceptance.
REQ-013 Write: IDLE->WR; AWVALID and WVALID rise together the cycle after acceptance.
REQ-014 AWVALID and WVALID each drop independently the cycle after their own handshake; WR->WAIT_B once both done, including same-cycle handshakes.
REQ-015 BREADY high only in WAIT_B; on BVALID capture BRESP, WAIT_B->RSP.
REQ-016 Read: IDLE->RD; ARVALID high until ARREADY; RD->WAIT_R; RREADY high only in WAIT_R; on RVALID capture RDATA/RRESP, WAIT_R->RSP.
REQ-017 AWADDR/WDATA/WSTRB/ARADDR stable from VALID rise until handshake; VALID never withdrawn before handshake.
REQ-018 RSP: rsp_valid high and payload stable until rsp_ready; RSP->IDLE on handshake; next command accepted no earlier than following cycle.
REQ-019 Minimum latency with always-ready slave: write acceptance T -> rsp_valid T+3; read T -> rsp_valid T+3.
REQ-020 BVALID/RVALID arriving outside WAIT_B/WAIT_R ignored (ready low); no spurious response.
REQ-021 Error RESP values passed through unmodified; no retry.

Reset
REQ-022 ARESETN low at any edge, including mid-transaction: state IDLE, all AXI VALID/READY outputs 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, address/data outputs 0.
REQ-023 cmd_ready 0 while ARESETN low; 1 first cycle after release.

Configuration
REQ-024 Macro AXI_LITE_MASTER_ALIGN_CHECK_EN defined: command with cmd_addr[1:0] != 0 goes IDLE->RSP directly, no AXI traffic, rsp_resp = 2'b10 (SLVERR), rsp_rdata = 0.
REQ-025 Macro undefined: address bits forwarded unchanged, no alignment check logic.

Structure
REQ-026 Package axi_lite_pkg holds RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state enum, default width constants.
REQ-027 Single flat module; no sub-module.

Verification
REQ-028 Write 0xC <= 0xDEADBEEF, WSTRB 0xF, into axi_lite_slave -> one AW and one W handshake, rsp_resp 0, rsp_write 1 at T+3.
REQ-029 Read 0xC after REQ-028 -> rsp_rdata 0xDEADBEEF, rsp_resp 0, rsp_write 0.
REQ-030 Stub slave: AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held with AWADDR stable, single response.
REQ-031 rsp_ready held low 5 cycles -> rsp_valid and payload stable, cmd_ready low throughout.
REQ-032 ARESETN low one cycle during WAIT_R -> all VALID/READY 0 next cycle, cmd_ready 1 after release, no response emitted.
REQ-033 With AXI_LITE_MASTER_ALIGN_CHECK_EN, read 0x6 -> no ARVALID, rsp_resp 2'b10 at T+1; without macro, ARADDR 0x6 issued.
